// File: rtl/sdram_pkg.sv
// Shared SDRAM command encodings, bus widths and arbiter state type.
package sdram_pkg;

  localparam int ADDR_W = 12;
  localparam int BA_W   = 2;

  localparam logic [3:0] CMD_NOP         = 4'b0111;
  localparam logic [3:0] CMD_PRECHARGE   = 4'b0010;
  localparam logic [3:0] CMD_AUTOREFRESH = 4'b0001;
  localparam logic [3:0] CMD_LOAD_MODE   = 4'b0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARBIT,
    ST_AREF,
    ST_WRITE,
    ST_READ
  } arb_state_t;

endpackage

// File: rtl/sdram_aref_timer.sv
// Periodic auto-refresh timer: raises aref_req every AREF_PERIOD cycles,
// flags a sticky miss if a new interval elapses with a request still pending.
module sdram_aref_timer #(
  parameter int AREF_PERIOD = 750,
  parameter int AREF_CNT_W  = 10
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic enable,
  input  logic ack,
  output logic aref_req,
  output logic aref_miss
);

  localparam logic [AREF_CNT_W-1:0] LAST =
    AREF_CNT_W'(AREF_PERIOD - 1);

  logic [AREF_CNT_W-1:0] cnt;
  logic                  wrap;

  assign wrap = enable && (cnt == LAST);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt <= '0;
    end else if (!enable || wrap) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Set beats ack so a wrap coinciding with a grant is not lost.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      aref_req <= 1'b0;
    end else if (wrap) begin
      aref_req <= 1'b1;
    end else if (ack) begin
      aref_req <= 1'b0;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      aref_miss <= 1'b0;
    end else if (wrap && aref_req) begin
      aref_miss <= 1'b1;
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// SDRAM bus arbiter: muxes init, refresh, write and read command sources
// onto the SDRAM pins with fixed priority refresh > write > read.
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter int AREF_PERIOD = 750,
  parameter int AREF_CNT_W  = 10
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [3:0]        init_cmd,
  input  logic [BA_W-1:0]   init_ba,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic              init_done,
  input  logic [3:0]        aref_cmd,
  input  logic [BA_W-1:0]   aref_ba,
  input  logic [ADDR_W-1:0] aref_addr,
  input  logic              aref_end,
  input  logic              wr_req,
  input  logic [3:0]        wr_cmd,
  input  logic [BA_W-1:0]   wr_ba,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_end,
  input  logic              rd_req,
  input  logic [3:0]        rd_cmd,
  input  logic [BA_W-1:0]   rd_ba,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_end,
  output logic              aref_req,
  output logic              aref_en,
  output logic              wr_en,
  output logic              rd_en,
  output logic              aref_miss,
  output logic [3:0]        sdram_cmd,
  output logic [BA_W-1:0]   sdram_ba,
  output logic [ADDR_W-1:0] sdram_addr
);

  arb_state_t state;
  arb_state_t state_nxt;
  logic       aref_ack;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (init_done) state_nxt = ST_ARBIT;
      end
      ST_ARBIT: begin
        if (aref_req)    state_nxt = ST_AREF;
        else if (wr_req) state_nxt = ST_WRITE;
        else if (rd_req) state_nxt = ST_READ;
      end
      ST_AREF: begin
        if (aref_end) state_nxt = ST_ARBIT;
      end
      ST_WRITE: begin
        if (wr_end) state_nxt = ST_ARBIT;
      end
      ST_READ: begin
        if (rd_end) state_nxt = ST_ARBIT;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign aref_en  = (state == ST_AREF);
  assign wr_en    = (state == ST_WRITE);
  assign rd_en    = (state == ST_READ);
  assign aref_ack = (state == ST_ARBIT) && aref_req;

  always_comb begin
    sdram_cmd  = init_cmd;
    sdram_ba   = init_ba;
    sdram_addr = init_addr;
    unique case (state)
      ST_ARBIT: begin
        sdram_cmd  = CMD_NOP;
        sdram_ba   = '1;
        sdram_addr = '1;
      end
      ST_AREF: begin
        sdram_cmd  = aref_cmd;
        sdram_ba   = aref_ba;
        sdram_addr = aref_addr;
      end
      ST_WRITE: begin
        sdram_cmd  = wr_cmd;
        sdram_ba   = wr_ba;
        sdram_addr = wr_addr;
      end
      ST_READ: begin
        sdram_cmd  = rd_cmd;
        sdram_ba   = rd_ba;
        sdram_addr = rd_addr;
      end
      default: begin
        sdram_cmd  = init_cmd;
        sdram_ba   = init_ba;
        sdram_addr = init_addr;
      end
    endcase
  end

  sdram_aref_timer #(
    .AREF_PERIOD (AREF_PERIOD),
    .AREF_CNT_W  (AREF_CNT_W)
  ) u_aref_timer (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .enable    (state != ST_IDLE),
    .ack       (aref_ack),
    .aref_req  (aref_req),
    .aref_miss (aref_miss)
  );

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Owns the SDRAM command/bank/address bus once power-up initialisation is finished.
- Multiplexes four command sources onto the bus: the init sequencer, the auto-refresh engine, the write engine and the read engine.
- Contains the periodic refresh timer, which raises refresh requests. Fixed priority for grants: refresh > write > read.
- Sits between the init, aref, write and read sub-controllers and the SDRAM pins.

Parameters:
AREF_PERIOD, 750, refresh interval in sys_clk cycles (7.5 us at 100 MHz)
AREF_CNT_W, 10, refresh timer width; must satisfy 2**AREF_CNT_W > AREF_PERIOD

Ports:
sys_clk  in  1  clock
sys_rst_n  in  1  asynchronous active-low reset
init_cmd  in  4  init command {cs_n,ras_n,cas_n,we_n}
init_ba  in  2  init bank address
init_addr  in  12  init address
init_done  in  1  init sequence complete (level)
aref_cmd / aref_ba / aref_addr  in  4/2/12  refresh engine command, bank, address
aref_end  in  1  one-cycle pulse: refresh sequence finished
wr_req  in  1  write engine requests bus (level)
wr_cmd / wr_ba / wr_addr  in  4/2/12  write engine command, bank, address
wr_end  in  1  one-cycle pulse: write burst finished
rd_req  in  1  read engine requests bus (level)
rd_cmd / rd_ba / rd_addr  in  4/2/12  read engine command, bank, address
rd_end  in  1  one-cycle pulse: read burst finished
aref_req  out  1  refresh pending; write/read engines terminate bursts early when set
aref_en  out  1  grant to refresh engine
wr_en  out  1  grant to write engine
rd_en  out  1  grant to read engine
aref_miss  out  1  sticky: refresh interval elapsed while previous request still pending
sdram_cmd  out  4  muxed command to SDRAM
sdram_ba  out  2  muxed bank address
sdram_addr  out  12  muxed address

Behaviour:
- Reset: state=IDLE, timer=0, aref_req=0, aref_miss=0, all *_en=0. Outputs sdram_* follow init_* (combinational mux driven from state).
- FSM states: IDLE, ARBIT, AREF, WRITE, READ.
  - IDLE: mux selects init_*. When init_done=1 → ARBIT next cycle.
  - ARBIT: sdram_cmd=NOP 4'b0111, ba=2'b11, addr=12'hFFF. Evaluated in priority order:
    - aref_req → AREF
    - else wr_req → WRITE
    - else rd_req → READ
    - else stay in ARBIT.
  - AREF: aref_en=1, mux selects aref_*. On aref_end → ARBIT.
  - WRITE: wr_en=1, mux selects wr_*. On wr_end → ARBIT.
  - READ: rd_en=1, mux selects rd_*. On rd_end → ARBIT.
- Grant timing: *_en is a decode of state, so it asserts the cycle after the ARBIT decision and drops the cycle after the *_end pulse.
- ARBIT always lasts ≥1 cycle between grants, guaranteeing one NOP on the bus.
- Requests are sampled only in ARBIT; *_req changes during another grant are ignored.
- *_end pulses are ignored outside the matching state.
- init_done is used only in IDLE; once ARBIT is reached, later deassertion is ignored. Only reset returns the FSM to IDLE.
- Refresh timer:
  - Held at 0 while state==IDLE. Otherwise increments each cycle.
  - At AREF_PERIOD-1, wraps to 0 and sets aref_req.
  - aref_req clears in the cycle the FSM moves ARBIT→AREF.
  - If the wrap occurs while aref_req is already 1, aref_req stays 1 and aref_miss sets; aref_miss clears only on reset.
  - Simultaneous wrap and ARBIT→AREF transition: set wins, so aref_req=1 for the next interval.
- Reset mid-operation (any state): immediate asynchronous return to reset values; the bus reverts to init_* in the same cycle.

Decomposition:
- Shared package sdram_pkg:
  - command localparams CMD_NOP=4'b0111, CMD_PRECHARGE=4'b0010, CMD_AUTOREFRESH=4'b0001, CMD_LOAD_MODE=4'b0000
  - arbiter state enum
  - SDRAM address/bank widths (12, 2)
- One sub-module, sdram_aref_timer: counter, aref_req set/clear, aref_miss. Inputs: enable (state!=IDLE) and ack (ARBIT→AREF). FSM and output mux stay in sdram_arbiter.

Test Plan:
- Init hold: init_done=0 for 100 cycles, init_cmd=4'b0010 → sdram_cmd=4'b0010 throughout; all *_en=0; aref_req stays 0.
- Single write: init_done=1, wr_req=1 → state ARBIT 1 cycle then WRITE; wr_en=1 and sdram_cmd=wr_cmd; wr_end pulse → wr_en=0 next cycle, then sdram_cmd=4'b0111.
- Priority: wr_req=1 and rd_req=1 together in ARBIT → WRITE granted; rd_en=0 until wr_end; then READ granted after one ARBIT NOP cycle.
- Refresh preemption: AREF_PERIOD=20; wr_req and rd_req held high → aref_req rises 20 cycles after ARBIT entry; after current wr_end the next grant is AREF (aref_en=1, sdram_cmd=aref_cmd); aref_req=0 after grant.
- Refresh overrun: AREF_PERIOD=20, write grant with wr_end withheld 45 cycles → aref_miss=1 at the second wrap and stays 1 after AREF completes.
- Reset mid-READ: assert sys_rst_n=0 during READ → rd_en=0 and sdram_cmd=init_cmd immediately; after release with init_done=1 → ARBIT, timer restarts from 0.
